// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - multi-master memory arbiter with mirrored internal RAM and timed external port
module mem_arb #(
    parameter int NREQ     = 2,
    parameter int AW       = 16,
    parameter int DW       = 8,
    parameter int RAM_AW   = 11,
    parameter int SEL_BITS = 3,
    parameter int RR       = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    wr,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic               ext_req,
    output logic [AW-1:0]      ext_addr,
    output logic [DW-1:0]      ext_wdata,
    output logic               ext_wr,
    input  logic [DW-1:0]      ext_rdata,
    input  logic               ext_ack,
    output logic               timeout,
    output logic               busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RAM, S_EXT, S_ACK} state_t;

    state_t            state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     idx;
    logic [RAM_AW-1:0] l_ram_addr;
    logic [DW-1:0]     l_wdata;
    logic              l_wr;
    logic              to_flag;
    logic [CW-1:0]     cnt;

    logic [DW-1:0]     mem [0:(1<<RAM_AW)-1];

    logic [IW-1:0]     win;
    logic              found;
    int                j;
    logic [AW-1:0]     win_addr;
    logic [DW-1:0]     win_wdata;
    logic              win_hit;

    // Pick the winning requester: fixed scan from 0, or rotating scan from ptr
    always_comb begin
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (RR != 0) j = (int'(ptr) + k) % NREQ;
            else         j = k;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = IW'(j);
            end
        end
        win_addr  = addr[int'(win)*AW +: AW];
        win_wdata = wdata[int'(win)*DW +: DW];
        win_hit   = (win_addr[AW-1 -: SEL_BITS] == '0);
    end

    // Access sequencer: grant, perform RAM or external access, then acknowledge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            ptr        <= '0;
            idx        <= '0;
            l_ram_addr <= '0;
            l_wdata    <= '0;
            l_wr       <= 1'b0;
            to_flag    <= 1'b0;
            cnt        <= '0;
            ack        <= '0;
            rdata      <= '0;
            ext_req    <= 1'b0;
            ext_addr   <= '0;
            ext_wdata  <= '0;
            ext_wr     <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ack     <= '0;
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    // While ack is still visible the master has not yet had a
                    // chance to change its request, so no new grant this cycle.
                    if (found && ack == '0) begin
                        idx        <= win;
                        l_ram_addr <= win_addr[RAM_AW-1:0];
                        l_wdata    <= win_wdata;
                        l_wr       <= wr[win];
                        ptr        <= IW'((int'(win) + 1) % NREQ);
                        to_flag    <= 1'b0;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        if (win_hit) begin
                            state <= S_RAM;
                        end else begin
                            state     <= S_EXT;
                            ext_addr  <= win_addr;
                            ext_wdata <= win_wdata;
                            ext_wr    <= wr[win];
                        end
                    end
                end
                S_RAM: begin
                    if (!l_wr) rdata <= mem[l_ram_addr];
                    state <= S_ACK;
                end
                S_EXT: begin
                    if (!ext_req) begin
                        ext_req <= 1'b1;
                    end else if (ext_ack) begin
                        ext_req <= 1'b0;
                        if (!l_wr) rdata <= ext_rdata;
                        state <= S_ACK;
                    end else if (TIMEOUT != 0 && int'(cnt) + 1 >= TIMEOUT) begin
                        // Abandon the access; rdata keeps its old value (open bus).
                        ext_req <= 1'b0;
                        to_flag <= 1'b1;
                        state   <= S_ACK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    ack[idx] <= 1'b1;
                    timeout  <= to_flag;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Work RAM write port, no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (state == S_RAM && l_wr) mem[l_ram_addr] <= l_wdata;
    end

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - directed table-driven bench for mem_arb
module tb_mem_arb;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [1:0]  req_a, wr_a, ack_a;
    logic [31:0] addr_a;
    logic [15:0] wdata_a;
    logic [7:0]  rdata_a, ext_wdata_a, ext_rdata_a;
    logic [15:0] ext_addr_a;
    logic        ext_req_a, ext_wr_a, ext_ack_a, timeout_a, busy_a;

    logic [3:0]  req_b, wr_b, ack_b;
    logic [63:0] addr_b;
    logic [31:0] wdata_b;
    logic [7:0]  rdata_b, ext_wdata_b, ext_rdata_b;
    logic [15:0] ext_addr_b;
    logic        ext_req_b, ext_wr_b, ext_ack_b, timeout_b, busy_b;

    mem_arb #(.NREQ(2), .TIMEOUT(8)) dut_a (
        .clk(clk), .rstn(rstn), .req(req_a), .wr(wr_a), .addr(addr_a), .wdata(wdata_a),
        .ack(ack_a), .rdata(rdata_a), .ext_req(ext_req_a), .ext_addr(ext_addr_a),
        .ext_wdata(ext_wdata_a), .ext_wr(ext_wr_a), .ext_rdata(ext_rdata_a),
        .ext_ack(ext_ack_a), .timeout(timeout_a), .busy(busy_a)
    );

    mem_arb #(.NREQ(4), .RAM_AW(10), .SEL_BITS(4), .RR(0)) dut_b (
        .clk(clk), .rstn(rstn), .req(req_b), .wr(wr_b), .addr(addr_b), .wdata(wdata_b),
        .ack(ack_b), .rdata(rdata_b), .ext_req(ext_req_b), .ext_addr(ext_addr_b),
        .ext_wdata(ext_wdata_b), .ext_wr(ext_wr_b), .ext_rdata(ext_rdata_b),
        .ext_ack(ext_ack_b), .timeout(timeout_b), .busy(busy_b)
    );

    logic sel;
    wire [3:0]  o_ack      = sel ? ack_b : {2'b00, ack_a};
    wire [7:0]  o_rdata    = sel ? rdata_b : rdata_a;
    wire        o_ext_req  = sel ? ext_req_b : ext_req_a;
    wire [15:0] o_ext_addr = sel ? ext_addr_b : ext_addr_a;
    wire [7:0]  o_ext_wd   = sel ? ext_wdata_b : ext_wdata_a;
    wire        o_ext_wr   = sel ? ext_wr_b : ext_wr_a;
    wire        o_timeout  = sel ? timeout_b : timeout_a;
    wire        o_busy     = sel ? busy_b : busy_a;

    int n_cmp  = 0;
    int n_fail = 0;
    int ext_dly = 0;
    logic [7:0] ext_dat = 8'h00;
    int ea_a, ea_b;

    // External target models: ack after ext_dly cycles of ext_req (0 = never)
    initial begin
        ext_ack_a = 1'b0; ext_rdata_a = 8'h00; ea_a = 0;
        forever begin
            @(negedge clk);
            if (ext_req_a) begin
                ea_a++;
                ext_ack_a   = (ext_dly != 0 && ea_a == ext_dly);
                ext_rdata_a = ext_dat;
            end else begin
                ea_a = 0; ext_ack_a = 1'b0;
            end
        end
    end

    initial begin
        ext_ack_b = 1'b0; ext_rdata_b = 8'h00; ea_b = 0;
        forever begin
            @(negedge clk);
            if (ext_req_b) begin
                ea_b++;
                ext_ack_b   = (ext_dly != 0 && ea_b == ext_dly);
                ext_rdata_b = ext_dat;
            end else begin
                ea_b = 0; ext_ack_b = 1'b0;
            end
        end
    end

    typedef struct {
        bit         on_b;
        int         m;
        bit         wr;
        logic [15:0] addr;
        logic [7:0] wdata;
        int         dly;
        logic [7:0] edata;
        logic [7:0] exp_rd;
        int         exp_lat;
        int         exp_ext;
        bit         exp_to;
    } vec_t;

    function automatic vec_t mk(input bit b, input int m, input bit w, input logic [15:0] a,
                                input logic [7:0] d, input int dly, input logic [7:0] ed,
                                input logic [7:0] rd, input int lat, input int ext, input bit to);
        vec_t v;
        v.on_b = b; v.m = m; v.wr = w; v.addr = a; v.wdata = d; v.dly = dly; v.edata = ed;
        v.exp_rd = rd; v.exp_lat = lat; v.exp_ext = ext; v.exp_to = to;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit b, input int m, input bit r, input bit w,
                         input logic [15:0] a, input logic [7:0] d);
        if (b) begin
            req_b[m] = r; wr_b[m] = w; addr_b[m*16 +: 16] = a; wdata_b[m*8 +: 8] = d;
        end else begin
            req_a[m] = r; wr_a[m] = w; addr_a[m*16 +: 16] = a; wdata_a[m*8 +: 8] = d;
        end
    endtask

    task automatic wait_ack(output logic [3:0] a, output logic [7:0] r, output int c);
        bit seen;
        seen = 1'b0; a = '0; r = '0; c = 0;
        while (!seen && c < 40) begin
            @(negedge clk); c++;
            if (o_ack != 0) begin seen = 1'b1; a = o_ack; r = o_rdata; end
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int lat, ext_hi;
        bit seen, ext_bad;
        logic [3:0] ackv;
        logic tov;
        logic [7:0] rd;
        sel = v.on_b; ext_dly = v.dly; ext_dat = v.edata;
        @(negedge clk);
        drive(v.on_b, v.m, 1'b1, v.wr, v.addr, v.wdata);
        lat = 0; ext_hi = 0; seen = 1'b0; ext_bad = 1'b0; ackv = '0; tov = 1'b0; rd = '0;
        while (!seen && lat < 300) begin
            @(negedge clk); lat++;
            if (o_ext_req) begin
                ext_hi++;
                if (o_ext_addr !== v.addr || o_ext_wr !== v.wr || (v.wr && o_ext_wd !== v.wdata))
                    ext_bad = 1'b1;
            end
            if (o_ack != 0) begin seen = 1'b1; ackv = o_ack; tov = o_timeout; rd = o_rdata; end
        end
        chk($sformatf("v%0d ack", n), 32'(ackv), 32'(4'b0001 << v.m));
        chk($sformatf("v%0d latency", n), lat, v.exp_lat);
        chk($sformatf("v%0d ext_req_cycles", n), ext_hi, v.exp_ext);
        chk($sformatf("v%0d ext_fields_stable", n), 32'(ext_bad), 32'd0);
        chk($sformatf("v%0d timeout", n), 32'(tov), 32'(v.exp_to));
        chk($sformatf("v%0d rdata", n), 32'(rd), 32'(v.exp_rd));
        @(negedge clk);
        chk($sformatf("v%0d rdata_held", n), 32'({o_ack, o_rdata}), 32'({4'b0000, v.exp_rd}));
        drive(v.on_b, v.m, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    vec_t vt[15];

    initial begin
        logic [3:0] a;
        logic [7:0] r;
        int c;
        bit up;

        vt[0]  = mk(0, 0, 1, 16'h0012, 8'h5A, 0, 8'h00, 8'h00, 3, 0, 0);
        vt[1]  = mk(0, 0, 0, 16'h0812, 8'h00, 0, 8'h00, 8'h5A, 3, 0, 0);
        vt[2]  = mk(0, 1, 1, 16'h07FF, 8'hA5, 0, 8'h00, 8'h5A, 3, 0, 0);
        vt[3]  = mk(0, 1, 0, 16'h1FFF, 8'h00, 0, 8'h00, 8'hA5, 3, 0, 0);
        vt[4]  = mk(0, 1, 0, 16'h8000, 8'h00, 5, 8'hC3, 8'hC3, 8, 5, 0);
        vt[5]  = mk(0, 0, 1, 16'h2000, 8'h66, 2, 8'hEE, 8'hC3, 5, 2, 0);
        vt[6]  = mk(0, 0, 0, 16'h0012, 8'h00, 0, 8'h00, 8'h5A, 3, 0, 0);
        vt[7]  = mk(0, 0, 1, 16'h0100, 8'h77, 0, 8'h00, 8'h5A, 3, 0, 0);
        vt[8]  = mk(0, 0, 0, 16'h0100, 8'h00, 0, 8'h00, 8'h77, 3, 0, 0);
        vt[9]  = mk(0, 0, 0, 16'h4018, 8'h00, 0, 8'hBB, 8'h77, 11, 8, 1);
        vt[10] = mk(0, 1, 0, 16'hFFFF, 8'h00, 1, 8'h3C, 8'h3C, 4, 1, 0);
        vt[11] = mk(1, 2, 1, 16'h0000, 8'h11, 0, 8'h00, 8'h00, 3, 0, 0);
        vt[12] = mk(1, 3, 0, 16'h0C00, 8'h00, 0, 8'h00, 8'h11, 3, 0, 0);
        vt[13] = mk(1, 1, 0, 16'h1000, 8'h00, 3, 8'h99, 8'h99, 6, 3, 0);
        vt[14] = mk(1, 0, 1, 16'h0C01, 8'h22, 0, 8'h00, 8'h99, 3, 0, 0);

        sel = 1'b0;
        rstn = 1'b0;
        req_a = '0; wr_a = '0; addr_a = '0; wdata_a = '0;
        req_b = '0; wr_b = '0; addr_b = '0; wdata_b = '0;
        repeat (3) @(negedge clk);
        chk("reset ack/ext_req/ext_wr/timeout/busy", 32'({o_ack, o_ext_req, o_ext_wr, o_timeout, o_busy}), 32'd0);
        chk("reset ext_addr/ext_wdata", 32'({o_ext_addr, o_ext_wd}), 32'd0);
        chk("reset rdata", 32'({rdata_a, rdata_b}), 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(i, vt[i]);

        // B: read back the mirrored write at 0x0001 (low 10 bits of 0x0C01)
        run_vec(15, mk(1, 0, 0, 16'h0001, 8'h00, 0, 8'h00, 8'h22, 3, 0, 0));

        // Reset asserted while an external access is outstanding
        sel = 1'b0; ext_dly = 0;
        @(negedge clk);
        drive(0, 1, 1'b1, 1'b0, 16'h9000, 8'h00);
        up = 1'b0; c = 0;
        while (!up && c < 10) begin @(negedge clk); c++; up = ext_req_a; end
        chk("ext_req rose before reset", 32'(up), 32'd1);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async reset ext_req/busy/ack", 32'({ext_req_a, busy_a, ack_a}), 32'd0);
        drive(0, 1, 1'b0, 1'b0, 16'h0000, 8'h00);
        @(negedge clk);
        rstn = 1'b1;

        // Round robin with both masters holding RAM reads; pointer starts at 0
        drive(0, 0, 1'b1, 1'b0, 16'h0012, 8'h00);
        drive(0, 1, 1'b1, 1'b0, 16'h07FF, 8'h00);
        for (int g = 0; g < 4; g++) begin
            wait_ack(a, r, c);
            chk($sformatf("rr grant %0d ack", g), 32'(a), (g % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("rr grant %0d rdata", g), 32'(r), (g % 2 == 0) ? 32'h5A : 32'hA5);
            chk($sformatf("rr grant %0d spacing", g), c, (g == 0) ? 3 : 4);
        end
        @(negedge clk);
        drive(0, 0, 1'b0, 1'b0, 16'h0000, 8'h00);
        drive(0, 1, 1'b0, 1'b0, 16'h0000, 8'h00);

        // Fixed priority on B: master 0 keeps requesting and starves master 1
        sel = 1'b1;
        @(negedge clk);
        drive(1, 0, 1'b1, 1'b0, 16'h0001, 8'h00);
        drive(1, 1, 1'b1, 1'b0, 16'h0C00, 8'h00);
        for (int g = 0; g < 3; g++) begin
            wait_ack(a, r, c);
            chk($sformatf("fixed grant %0d ack", g), 32'(a), 32'd1);
            chk($sformatf("fixed grant %0d rdata", g), 32'(r), 32'h22);
        end
        @(negedge clk);
        drive(1, 0, 1'b0, 1'b0, 16'h0000, 8'h00);
        wait_ack(a, r, c);
        chk("fixed waiter ack", 32'(a), 32'd2);
        chk("fixed waiter rdata", 32'(r), 32'h11);
        chk("fixed waiter latency", c, 3);
        @(negedge clk);
        drive(1, 1, 1'b0, 1'b0, 16'h0000, 8'h00);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
# mem_arb

Parametrised multi-requester memory arbiter with built-in work RAM for the CPU address space. It arbitrates NREQ bus masters (CPU, OAM/DMC DMA, debug port, …) by fixed or round-robin priority. Hits in the low region are served from an internal mirrored RAM; all other addresses are forwarded to one external target port with a timeout. Sits between the masters and the PPU/IO/PRG decode, replacing the two-master halt-steered mux.

## Interface
Parameters:
- NREQ, 2: number of requesters; index 0 is highest fixed priority.
- AW, 16: address width.
- DW, 8: data width.
- RAM_AW, 11: internal RAM address bits; depth 2^RAM_AW.
- SEL_BITS, 3: RAM region is addr[AW-1:AW-SEL_BITS]==0 and is mirrored through addr[RAM_AW-1:0].
- RR, 1: 1 = round-robin, 0 = fixed priority.
- TIMEOUT, 255: external wait limit in cycles; 0 disables the timeout.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- req  in  NREQ  per-master request level.
- wr  in  NREQ  per-master write flag.
- addr  in  NREQ*AW  packed addresses; master i uses [i*AW +: AW].
- wdata  in  NREQ*DW  packed write data.
- ack  out  NREQ  one-cycle completion pulse, one-hot.
- rdata  out  DW  shared read data, valid while ack is high and held afterwards.
- ext_req  out  1  external request level.
- ext_addr  out  AW  external address.
- ext_wdata  out  DW  external write data.
- ext_wr  out  1  external write flag.
- ext_rdata  in  DW  external read data, valid with ext_ack.
- ext_ack  in  1  external completion pulse.
- timeout  out  1  one-cycle pulse when an external access is abandoned.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: if any req is set, select a winner; latch its index, addr, wdata and wr. Go to RAM if the address hits the RAM region, otherwise go to EXT.
  - RAM: write ram[addr[RAM_AW-1:0]] or read it into rdata; go to ACK.
  - EXT: hold ext_req=1 and count cycles.
    - On ext_ack: latch ext_rdata into rdata (reads only), go to ACK.
    - When the counter reaches TIMEOUT with TIMEOUT≠0: leave rdata unchanged (open bus), pulse timeout, go to ACK.
  - ACK: ack[idx]=1; go to IDLE.
- Arbitration:
  - RR=0: the lowest set index wins.
  - RR=1: the search starts at pointer ptr and wraps modulo NREQ. On every grant ptr becomes (winner+1) mod NREQ.
- Request rules:
  - A master holds req, addr, wdata and wr stable until its ack.
  - In the cycle after ack it may drop req or present a new request.
  - Dropping req before ack is illegal. The latched request still completes.
- Writes leave rdata unchanged. rdata always holds the last read value, which gives open-bus behaviour.
- ext_addr, ext_wdata and ext_wr are driven from the latched request and are stable for the whole time ext_req is high.
- ext_ack received outside EXT is ignored.
- A write to the RAM region never reaches the external port.

## Timing
- Reset values: ack=0, ext_req=0, ext_wr=0, ext_addr=0, ext_wdata=0, rdata=0, timeout=0, busy=0, state=IDLE, ptr=0, counter=0. RAM contents are undefined.
- Reset asserted mid-access drops ext_req and ack immediately. The in-flight transaction is lost.
- RAM access: req sampled at edge t → RAM at t+1 → ack high during the cycle after edge t+2.
  - The earliest next grant is at edge t+4.
  - Throughput is one access per 4 cycles.
- External access: ext_req rises after edge t+1 and falls on the edge that samples ext_ack. ack is high one cycle later.
- Timeout: with ext_ack never returning, ext_req is high for exactly TIMEOUT cycles; timeout and ack are asserted together in the following cycle.
- Simultaneous requests: exactly one grant per IDLE visit. Losing masters keep waiting with no ack.
- The counter is ceil(log2(TIMEOUT+1)) bits wide and clears on entry to EXT.

## Test plan
- Single master 0 writes 0x5A to 0x0012, then reads 0x0812 (mirror) → ack pulses 4 cycles apart; read rdata=0x5A; ext_req never rises.
- RR=1, masters 0 and 1 hold req continuously (all RAM accesses) → grants alternate 0,1,0,1.
  - Repeat with RR=0 and master 0 re-requesting immediately after each ack → master 0 always wins; master 1 waits.
- Master 1 reads 0x8000; the external model returns 0xC3 with ext_ack 5 cycles after ext_req rises → ext_addr=0x8000 while ext_req is high; ack[1] one cycle after ext_ack; rdata=0xC3.
- TIMEOUT=8, read of 0x4018 with no ext_ack, previous rdata 0x77 → ext_req high for exactly 8 cycles; timeout and ack pulse together; rdata stays 0x77.
- Pull rstn low during EXT → ext_req=0, busy=0 and ack=0 immediately; after release, a RAM read completes normally with round-robin pointer 0.
- NREQ=4, RAM_AW=10, SEL_BITS=4: write 0x11 to 0x0000, read 0x0C00 → rdata=0x11; read 0x1000 → goes to the external port.
